// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer: NUM_EVALS precharge/fire/sample passes per challenge with per-bit majority vote.
// Optional macro PUF_STABILITY_MASK_EN adds resp_stable / stable_cnt outputs and delays resp_valid by one cycle.
module puf_eval_ctrl #(
  parameter int NUM_EVALS        = 5,
  parameter int SETTLE_CYCLES    = 8,
  parameter int PRECHARGE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        chal_valid,
  output logic        chal_ready,
  input  logic [63:0] chal,
  output logic        puf_s,
  output logic [63:0] puf_c,
  input  logic [63:0] puf_q,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp,
  output logic        busy
`ifdef PUF_STABILITY_MASK_EN
  ,
  output logic [63:0] resp_stable,
  output logic [6:0]  stable_cnt
`endif
);

  localparam int CW   = $clog2(NUM_EVALS + 1);
  localparam int TMAX = (SETTLE_CYCLES > PRECHARGE_CYCLES) ? SETTLE_CYCLES : PRECHARGE_CYCLES;
  localparam int TW   = $clog2(TMAX);

  localparam logic [TW-1:0] PRE_LAST  = TW'(PRECHARGE_CYCLES - 1);
  localparam logic [TW-1:0] SET_LAST  = TW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] EVAL_LAST = CW'(NUM_EVALS - 1);
  localparam logic [CW-1:0] HALF      = CW'(NUM_EVALS / 2);

  typedef enum logic [2:0] {IDLE, PRECHARGE, FIRE, SAMPLE, DONE} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_eval_cnt;
  logic [CW-1:0] r_cnt [64];
  logic [63:0]   r_q_meta;
  logic [63:0]   r_q_sync;
  logic          r_puf_s;
  logic [63:0]   r_puf_c;
  logic          r_chal_ready;
  logic          r_resp_valid;
  logic [63:0]   r_resp;
  logic [63:0]   w_vote;

`ifdef PUF_STABILITY_MASK_EN
  localparam logic [CW-1:0] FULL = CW'(NUM_EVALS);
  logic [63:0] r_resp_stable;
  logic [6:0]  r_stable_cnt;
  logic        r_vote_done;
  logic [63:0] w_stable;
  logic [6:0]  w_pop;

  always_comb begin
    w_stable = '0;
    w_pop    = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      w_stable[i] = (r_cnt[i] == '0) || (r_cnt[i] == FULL);
      w_pop       = w_pop + 7'(r_resp_stable[i]);
    end
  end

  assign resp_stable = r_resp_stable;
  assign stable_cnt  = r_stable_cnt;
`endif

  always_comb begin
    w_vote = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      w_vote[i] = r_cnt[i] > HALF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_meta <= '0;
      r_q_sync <= '0;
    end else begin
      r_q_meta <= puf_q;
      r_q_sync <= r_q_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_eval_cnt   <= '0;
      r_puf_s      <= 1'b0;
      r_puf_c      <= '0;
      r_chal_ready <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp       <= '0;
      for (int unsigned i = 0; i < 64; i++) r_cnt[i] <= '0;
`ifdef PUF_STABILITY_MASK_EN
      r_resp_stable <= '0;
      r_stable_cnt  <= '0;
      r_vote_done   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_chal_ready <= 1'b1;
          if (chal_valid && r_chal_ready) begin
            r_puf_c      <= chal;
            r_eval_cnt   <= '0;
            r_timer      <= '0;
            r_chal_ready <= 1'b0;
            r_state      <= PRECHARGE;
            for (int unsigned i = 0; i < 64; i++) r_cnt[i] <= '0;
          end
        end
        PRECHARGE: begin
          if (r_timer == PRE_LAST) begin
            r_timer <= '0;
            r_puf_s <= 1'b1;
            r_state <= FIRE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        // puf_s falls on the FIRE->SAMPLE edge so the high time is exactly SETTLE_CYCLES
        FIRE: begin
          if (r_timer == SET_LAST) begin
            r_puf_s <= 1'b0;
            r_state <= SAMPLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        SAMPLE: begin
          for (int unsigned i = 0; i < 64; i++) r_cnt[i] <= r_cnt[i] + CW'(r_q_sync[i]);
          r_eval_cnt <= r_eval_cnt + 1'b1;
          r_puf_s    <= 1'b0;
          r_timer    <= '0;
          r_state    <= (r_eval_cnt == EVAL_LAST) ? DONE : PRECHARGE;
        end
        DONE: begin
`ifdef PUF_STABILITY_MASK_EN
          if (!r_vote_done) begin
            r_resp        <= w_vote;
            r_resp_stable <= w_stable;
            r_vote_done   <= 1'b1;
          end else if (!r_resp_valid) begin
            r_stable_cnt <= w_pop;
            r_resp_valid <= 1'b1;
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_vote_done  <= 1'b0;
            r_chal_ready <= 1'b1;
            r_state      <= IDLE;
          end
`else
          if (!r_resp_valid) begin
            r_resp       <= w_vote;
            r_resp_valid <= 1'b1;
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_chal_ready <= 1'b1;
            r_state      <= IDLE;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign chal_ready = r_chal_ready;
  assign puf_s      = r_puf_s;
  assign puf_c      = r_puf_c;
  assign resp_valid = r_resp_valid;
  assign resp       = r_resp;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed self-checking bench for puf_eval_ctrl: default instance plus a NUM_EVALS=1 / SETTLE_CYCLES=3 instance.
module tb_puf_eval_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chal_valid, chal_ready, puf_s, resp_valid, resp_ready, busy;
  logic [63:0] chal, puf_c, puf_q, resp;
  logic        chal_valid1, chal_ready1, puf_s1, resp_valid1, resp_ready1, busy1;
  logic [63:0] chal1, puf_c1, puf_q1, resp1;
`ifdef PUF_STABILITY_MASK_EN
  logic [63:0] resp_stable, resp_stable1;
  logic [6:0]  stable_cnt, stable_cnt1;
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [63:0] BASE  = 64'hDEADBEEF_01234567;
  localparam logic [63:0] NOISY = 64'hDEADBEEF_01234565;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  puf_eval_ctrl dut (
    .clk(clk), .rst_n(rst_n), .chal_valid(chal_valid), .chal_ready(chal_ready), .chal(chal),
    .puf_s(puf_s), .puf_c(puf_c), .puf_q(puf_q), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp(resp), .busy(busy)
`ifdef PUF_STABILITY_MASK_EN
    , .resp_stable(resp_stable), .stable_cnt(stable_cnt)
`endif
  );

  puf_eval_ctrl #(.NUM_EVALS(1), .SETTLE_CYCLES(3), .PRECHARGE_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .chal_valid(chal_valid1), .chal_ready(chal_ready1), .chal(chal1),
    .puf_s(puf_s1), .puf_c(puf_c1), .puf_q(puf_q1), .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp(resp1), .busy(busy1)
`ifdef PUF_STABILITY_MASK_EN
    , .resp_stable(resp_stable1), .stable_cnt(stable_cnt1)
`endif
  );

  function automatic logic [63:0] model(input int mode, input int pass);
    logic [4:0]  t0, t1;
    logic [63:0] v;
    t0 = 5'b10101;
    t1 = 5'b10100;
    v  = BASE;
    if (mode == 1) begin
      v[0] = t0[pass];
      v[1] = t1[pass];
    end
    return v;
  endfunction

  // Called at #1 after the accept edge; returns once resp_valid is seen or the cycle budget runs out.
  task automatic wait_resp(input int mode, input logic [63:0] c, output int lat, output int pulses,
                           output int minw, output int maxw, output bit cok);
    int  w;
    bit  prev;
    lat = 0; pulses = 0; minw = 1000; maxw = 0; cok = 1'b1; w = 0; prev = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      lat++;
      if (puf_s && !prev) begin
        if (pulses < 5) puf_q = model(mode, pulses);
        pulses++;
        w = 1;
      end else if (puf_s) begin
        w++;
      end else if (prev) begin
        if (w < minw) minw = w;
        if (w > maxw) maxw = w;
      end
      if (puf_s && puf_c !== c) cok = 1'b0;
      prev = puf_s;
      if (resp_valid) break;
    end
  endtask

  task automatic accept(input logic [63:0] c);
    chal = c; chal_valid = 1'b1;
    @(posedge clk); #1;
    chal_valid = 1'b0;
  endtask

  task automatic finish_handshake();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; chal_valid = 1'b0; resp_ready = 1'b0; chal = '0; puf_q = '0;
    chal_valid1 = 1'b0; resp_ready1 = 1'b0; chal1 = '0; puf_q1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (puf_s !== 1'b0 || puf_c !== '0 || resp !== '0 || resp_valid !== 1'b0 || chal_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: puf_s=%b puf_c=%h resp=%h resp_valid=%b chal_ready=%b busy=%b, required all 0",
               puf_s, puf_c, resp, resp_valid, chal_ready, busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (chal_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: chal_ready=%b busy=%b resp_valid=%b, required 1 0 0", chal_ready, busy, resp_valid);
    end
  endtask

  task automatic test_mid_reset();
    bit seen, emitted;
    accept(64'h0F0F_0F0F_0F0F_0F0F);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(posedge clk); #1;
      if (puf_s) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_reset_fire: puf_s never rose within 50 cycles, required 1");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (puf_s !== 1'b0 || busy !== 1'b0 || puf_c !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: puf_s=%b busy=%b puf_c=%h, required 0 0 0", puf_s, busy, puf_c);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || chal_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: busy=%b chal_ready=%b resp_valid=%b, required 0 1 0", busy, chal_ready, resp_valid);
    end
    emitted = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (resp_valid || busy) emitted = 1'b1;
    end
    checks++;
    if (emitted) begin
      errors++;
      $display("FAIL mid_reset_discard: resp_valid/busy=1 after reset, required 0");
    end
  endtask

  task automatic test_const();
    int lat, pulses, minw, maxw;
    bit cok;
    accept(64'h1111_2222_3333_4444);
    wait_resp(0, 64'h1111_2222_3333_4444, lat, pulses, minw, maxw, cok);
    checks++;
    if (lat !== 66 + EXTRA) begin
      errors++;
      $display("FAIL const_latency: got %0d, required %0d", lat, 66 + EXTRA);
    end
    checks++;
    if (pulses !== 5 || minw !== 8 || maxw !== 8) begin
      errors++;
      $display("FAIL const_pulses: count=%0d min=%0d max=%0d, required 5 8 8", pulses, minw, maxw);
    end
    checks++;
    if (!cok) begin
      errors++;
      $display("FAIL const_puf_c: puf_c differed from challenge while puf_s=1");
    end
    checks++;
    if (resp !== BASE) begin
      errors++;
      $display("FAIL const_resp: got %h, required %h", resp, BASE);
    end
`ifdef PUF_STABILITY_MASK_EN
    checks++;
    if (resp_stable !== '1 || stable_cnt !== 7'd64) begin
      errors++;
      $display("FAIL const_stable: mask=%h cnt=%0d, required all-ones 64", resp_stable, stable_cnt);
    end
`endif
    finish_handshake();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL const_return: busy=%b resp_valid=%b, required 0 0", busy, resp_valid);
    end
  endtask

  task automatic test_noisy();
    int lat, pulses, minw, maxw;
    bit cok;
    accept(64'hAAAA_5555_AAAA_5555);
    wait_resp(1, 64'hAAAA_5555_AAAA_5555, lat, pulses, minw, maxw, cok);
    checks++;
    if (resp !== NOISY || resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL noisy_resp: got %h valid=%b, required %h 1", resp, resp_valid, NOISY);
    end
`ifdef PUF_STABILITY_MASK_EN
    checks++;
    if (resp_stable !== 64'hFFFF_FFFF_FFFF_FFFC || stable_cnt !== 7'd62) begin
      errors++;
      $display("FAIL noisy_stable: mask=%h cnt=%0d, required fffffffffffffffc 62", resp_stable, stable_cnt);
    end
`endif
    finish_handshake();
  endtask

  task automatic test_hold_resp();
    int lat, pulses, minw, maxw;
    bit cok;
    logic [63:0] held;
    accept(64'h1234_5678_9ABC_DEF0);
    wait_resp(0, 64'h1234_5678_9ABC_DEF0, lat, pulses, minw, maxw, cok);
    held = resp;
    chal = 64'hFFFF_0000_FFFF_0000;
    for (int n = 0; n < 20; n++) begin
      chal_valid = n[0];
      @(posedge clk); #1;
      checks++;
      if (resp !== held || resp_valid !== 1'b1 || chal_ready !== 1'b0 || puf_c !== 64'h1234_5678_9ABC_DEF0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: resp=%h valid=%b chal_ready=%b puf_c=%h, required %h 1 0 123456789abcdef0",
                 n, resp, resp_valid, chal_ready, puf_c, held);
      end
    end
    chal_valid = 1'b0;
    finish_handshake();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || chal_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: busy=%b resp_valid=%b chal_ready=%b, required 0 0 1", busy, resp_valid, chal_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat, pulses, minw, maxw;
    bit cok, seen, cstable;
    logic [63:0] prev_c;
    logic prev_s;
    resp_ready = 1'b1;
    chal = 64'hCAFE_F00D_0000_0001; chal_valid = 1'b1;
    @(posedge clk); #1;
    chal = 64'hBEEF_0000_CAFE_0002;
    puf_q = BASE;
    seen = 1'b0; cstable = 1'b1; prev_c = puf_c; prev_s = puf_s;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk); #1;
      if (puf_c !== prev_c && (puf_s || prev_s)) cstable = 1'b0;
      prev_c = puf_c; prev_s = puf_s;
      if (resp_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || resp !== BASE) begin
      errors++;
      $display("FAIL b2b_first: seen=%b resp=%h, required 1 %h", seen, resp, BASE);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || chal_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b chal_ready=%b resp_valid=%b, required 0 1 0", busy, chal_ready, resp_valid);
    end
    @(posedge clk); #1;
    chal_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || puf_c !== 64'hBEEF_0000_CAFE_0002 || puf_s !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b puf_c=%h puf_s=%b, required 1 beef0000cafe0002 0", busy, puf_c, puf_s);
    end
    wait_resp(0, 64'hBEEF_0000_CAFE_0002, lat, pulses, minw, maxw, cok);
    checks++;
    if (lat !== 66 + EXTRA || !cok || !cstable || resp !== BASE) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d cok=%b cstable=%b resp=%h, required %0d 1 1 %h",
               lat, cok, cstable, resp, 66 + EXTRA, BASE);
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_single_eval();
    int lat, pulses, w;
    bit prev;
    lat = 0; pulses = 0; w = 0; prev = 1'b0;
    puf_q1 = 64'h0123_4567_89AB_CDEF;
    chal1 = 64'h5A5A_5A5A_5A5A_5A5A; chal_valid1 = 1'b1;
    @(posedge clk); #1;
    chal_valid1 = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      lat++;
      if (puf_s1 && !prev) pulses++;
      if (puf_s1) w++;
      prev = puf_s1;
      if (resp_valid1) break;
    end
    checks++;
    if (lat !== 9 + EXTRA || pulses !== 1 || w !== 3) begin
      errors++;
      $display("FAIL single_timing: lat=%0d pulses=%0d width=%0d, required %0d 1 3", lat, pulses, w, 9 + EXTRA);
    end
    checks++;
    if (resp1 !== 64'h0123_4567_89AB_CDEF || resp_valid1 !== 1'b1) begin
      errors++;
      $display("FAIL single_resp: got %h valid=%b, required 0123456789abcdef 1", resp1, resp_valid1);
    end
`ifdef PUF_STABILITY_MASK_EN
    checks++;
    if (resp_stable1 !== '1 || stable_cnt1 !== 7'd64) begin
      errors++;
      $display("FAIL single_stable: mask=%h cnt=%0d, required all-ones 64", resp_stable1, stable_cnt1);
    end
`endif
    resp_ready1 = 1'b1;
    @(posedge clk); #1;
    resp_ready1 = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || resp_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL single_return: busy=%b resp_valid=%b, required 0 0", busy1, resp_valid1);
    end
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_const();
    test_noisy();
    test_hold_resp();
    test_back_to_back();
    test_single_eval();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
- Sequences one evaluation of the 64-bit arbiter PUF array: latches a challenge, drives the shared start line, waits for the arbiters to settle and captures the response.
- Repeats the evaluation NUM_EVALS times and majority-votes each response bit to suppress metastable or noisy arbiters.
- Sits between the host request interface and the PUF array; it owns the array's start and challenge inputs.

Parameters:
- NUM_EVALS, 5, evaluations per challenge; odd, 1..15
- SETTLE_CYCLES, 8, clk cycles puf_s is held high before sampling; >= 3
- PRECHARGE_CYCLES, 4, clk cycles puf_s is held low before each rising edge; >= 1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- chal_valid  in  1  host challenge valid
- chal_ready  out  1  controller accepts challenge
- chal  in  64  challenge word
- puf_s  out  1  start line to the PUF array
- puf_c  out  64  challenge to the PUF array, registered
- puf_q  in  64  raw PUF response, asynchronous to clk
- resp_valid  out  1  voted response valid
- resp_ready  in  1  host accepts response
- resp  out  64  majority-voted response
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous on rst_n low. Reset values:
  - state=IDLE, puf_s=0, puf_c=0, resp=0, resp_valid=0, chal_ready=0 during reset.
  - All vote counters, eval_cnt and the timer are 0.
- puf_q passes through a 2-flop synchronizer. The sample taken is the synchronized value at the end of SETTLE.
- Vote counters: 64 counters, each $clog2(NUM_EVALS+1) bits wide. They never overflow because max = NUM_EVALS.
- IDLE:
  - chal_ready=1.
  - On chal_valid&&chal_ready: puf_c<=chal, counters and eval_cnt cleared, timer<=0, go to PRECHARGE.
- PRECHARGE:
  - puf_s=0; timer counts to PRECHARGE_CYCLES-1, then go to FIRE, timer<=0.
- FIRE:
  - puf_s<=1; timer counts to SETTLE_CYCLES-1, then go to SAMPLE.
- SAMPLE (1 cycle):
  - counter[i] += sync_q[i]; eval_cnt++; puf_s<=0.
  - If eval_cnt+1==NUM_EVALS, go to DONE; else go to PRECHARGE, timer<=0.
- DONE:
  - resp[i] <= (counter[i] > NUM_EVALS/2), registered on DONE entry.
  - resp_valid=1. resp is held stable until resp_ready, then go to IDLE.
  - resp_valid is dropped the cycle after the handshake.
- Latency from challenge accept to resp_valid:
  - NUM_EVALS*(PRECHARGE_CYCLES+SETTLE_CYCLES+1)+1 cycles.
  - Defaults: 66 cycles.
- Handshake rules:
  - chal_ready=0 outside IDLE; chal_valid is ignored there.
  - resp_ready while resp_valid=0 has no effect.
- puf_c is stable from accept until the next accept. It is never changed while puf_s=1.
- Reset mid-operation: puf_s drops immediately (asynchronous), the in-flight evaluation is discarded and no response is emitted.
- NUM_EVALS=1: a single pass; resp equals the single sample.

Optional Feature:
- Macro: PUF_STABILITY_MASK_EN.
- When defined:
  - Adds output resp_stable[63:0], registered with resp.
  - Bit i=1 iff counter[i]==0 or counter[i]==NUM_EVALS (unanimous); reset value 0.
  - Adds output stable_cnt[6:0], the popcount of resp_stable, registered one cycle after resp. resp_valid is delayed by that one cycle so both outputs are valid together.
- When undefined: neither port exists and latency is as stated above.

Test Plan:
- Reset with rst_n=0 mid-FIRE (puf_s=1) -> puf_s=0 within the same cycle; after release: busy=0, chal_ready=1, resp_valid=0.
- puf_q model returns 64'hDEADBEEF_01234567 on every pass, default parameters -> resp=64'hDEADBEEF_01234567, resp_valid at cycle 66 after accept; puf_s shows 5 pulses, each 8 cycles high.
- Noisy model: bit 0 reads 1,0,1,0,1 and bit 1 reads 0,0,1,0,1 across passes -> resp[0]=1, resp[1]=0; with PUF_STABILITY_MASK_EN: resp_stable[1:0]=2'b00.
- Hold resp_ready=0 for 20 cycles after resp_valid -> resp and resp_valid stable; chal_valid pulses are ignored (chal_ready=0). Assert resp_ready -> IDLE the next cycle.
- Back-to-back: chal_valid held high with a new challenge and resp_ready tied to 1 -> the second challenge is accepted the cycle after the IDLE return; puf_c updates only while puf_s=0.
- NUM_EVALS=1, SETTLE_CYCLES=3 -> single pulse; latency = 1*(4+3+1)+1 = 9 cycles; resp = synchronized puf_q.
